// File: rtl/poly_mult_driver.sv
// poly_mult_driver: stream-to-operand packer and product streamer that drives
// a polynomial multiplier over its start/done handshake. One job in flight.
module poly_mult_driver #(
   parameter int unsigned N       = 8,
   parameter int unsigned W       = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_coef,
   output logic                  mul_start,
   output logic [N-1:0][W-1:0]   mul_as,
   output logic [N-1:0][W-1:0]   mul_bs,
   input  logic [N-1:0][W-1:0]   mul_cs,
   input  logic                  mul_done,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [W-1:0]          out_coef,
   output logic                  out_last,
   output logic                  busy,
   output logic                  err
);

   localparam int unsigned CNT_W  = $clog2(2 * N);
   localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  CNT_N     = CNT_W'(N);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(2 * N - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]                r_state;
   logic [CNT_W-1:0]          r_cnt;
   logic [IDX_W-1:0]          r_idx;
   logic [WCNT_W-1:0]         r_wcnt;
   logic [N-1:0][W-1:0]       r_as;
   logic [N-1:0][W-1:0]       r_bs;
   logic [N-1:0][W-1:0]       r_res;
   logic                      r_in_ready;
   logic                      r_start;
   logic                      r_out_valid;
   logic [W-1:0]              r_out_coef;
   logic                      r_out_last;
   logic                      r_busy;
   logic                      r_err;

   logic [1:0]                w_state_nxt;
   logic [CNT_W-1:0]          w_cnt_nxt;
   logic [IDX_W-1:0]          w_idx_nxt;
   logic [WCNT_W-1:0]         w_wcnt_nxt;
   logic [N-1:0][W-1:0]       w_as_nxt;
   logic [N-1:0][W-1:0]       w_bs_nxt;
   logic [N-1:0][W-1:0]       w_res_nxt;
   logic                      w_err_nxt;
   logic [CNT_W-1:0]          w_slot;
   logic                      w_in_acc;
   logic                      w_out_acc;

   // Next-state, buffer update and next-output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_wcnt_nxt  = r_wcnt;
      w_as_nxt    = r_as;
      w_bs_nxt    = r_bs;
      w_res_nxt   = r_res;
      w_err_nxt   = 1'b0;
      w_in_acc    = in_valid && r_in_ready;
      w_out_acc   = r_out_valid && out_ready;
      w_slot      = (r_cnt < CNT_N) ? r_cnt : (r_cnt - CNT_N);

      case (r_state)
         ST_LOAD: begin
            if (w_in_acc) begin
               if (r_cnt < CNT_N) begin
                  w_as_nxt[IDX_W'(w_slot)] = in_coef;
               end else begin
                  w_bs_nxt[IDX_W'(w_slot)] = in_coef;
               end
               if (r_cnt == CNT_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_START;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_START: begin
            // The start cycle counts toward the timeout budget.
            w_wcnt_nxt  = r_wcnt + WCNT_W'(1);
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (mul_done) begin
               w_res_nxt   = mul_cs;
               w_idx_nxt   = '0;
               w_wcnt_nxt  = '0;
               w_state_nxt = ST_DRAIN;
            end else if (r_wcnt == WCNT_LAST) begin
               w_err_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_wcnt_nxt  = '0;
               w_state_nxt = ST_LOAD;
            end else begin
               w_wcnt_nxt = r_wcnt + WCNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (w_out_acc) begin
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = ST_LOAD;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_wcnt_nxt  = '0;
         end
      endcase
   end

   // State, buffers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_LOAD;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_wcnt      <= '0;
         r_as        <= '0;
         r_bs        <= '0;
         r_res       <= '0;
         r_in_ready  <= 1'b1;
         r_start     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_coef  <= '0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_wcnt      <= w_wcnt_nxt;
         r_as        <= w_as_nxt;
         r_bs        <= w_bs_nxt;
         r_res       <= w_res_nxt;
         r_in_ready  <= (w_state_nxt == ST_LOAD);
         r_start     <= (w_state_nxt == ST_START);
         r_out_valid <= (w_state_nxt == ST_DRAIN);
         r_out_coef  <= (w_state_nxt == ST_DRAIN) ? w_res_nxt[w_idx_nxt] : '0;
         r_out_last  <= (w_state_nxt == ST_DRAIN) && (w_idx_nxt == IDX_LAST);
         r_busy      <= !((w_state_nxt == ST_LOAD) && (w_cnt_nxt == '0));
         r_err       <= w_err_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign mul_start = r_start;
   assign mul_as    = r_as;
   assign mul_bs    = r_bs;
   assign out_valid = r_out_valid;
   assign out_coef  = r_out_coef;
   assign out_last  = r_out_last;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule

// File: tb/tb_poly_mult_driver.sv
// tb_poly_mult_driver: directed bench with a behavioural negacyclic multiplier
// and a coefficient scoreboard.
module tb_poly_mult_driver;

   localparam int unsigned N  = 8;
   localparam int unsigned W  = 8;
   localparam int unsigned TO = 16;

   typedef logic [N-1:0][W-1:0] vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_coef = '0;
   logic          mul_start;
   vec_t          mul_as, mul_bs, mul_cs;
   logic          mul_done;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_coef;
   logic          out_last, busy, err;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   // Multiplier model state
   bit   model_en   = 1'b1;
   int   done_delay = 5;
   bit   m_busy     = 1'b0;
   int   m_cnt      = 0;
   logic m_done     = 1'b0;
   vec_t m_cs       = '0;
   logic stray      = 1'b0;

   assign mul_done = m_done | stray;
   assign mul_cs   = stray ? {N{8'hEE}} : m_cs;

   poly_mult_driver #(.N(N), .W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
      .mul_start(mul_start), .mul_as(mul_as), .mul_bs(mul_bs),
      .mul_cs(mul_cs), .mul_done(mul_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
      .out_last(out_last), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Product modulo x^N + 1, coefficients modulo 2^W.
   function automatic vec_t pmul(input vec_t a, input vec_t b);
      vec_t c = '0;
      logic [W-1:0] p;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            p = W'(a[i] * b[j]);
            if (i + j < N) c[i + j]     = c[i + j] + p;
            else           c[i + j - N] = c[i + j - N] - p;
         end
      end
      return c;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 255));
      return v;
   endfunction

   // Behavioural multiplier: done done_delay cycles after start; ignores reset.
   always @(posedge clk) begin
      m_done <= 1'b0;
      if (mul_start && model_en) begin
         m_busy <= 1'b1;
         m_cnt  <= 1;
         m_cs   <= pmul(mul_as, mul_bs);
      end else if (m_busy) begin
         if (m_cnt >= done_delay - 1) begin
            m_done <= 1'b1;
            m_busy <= 1'b0;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 1);
      chk({tag, "_outs"}, {59'd0, mul_start, out_valid, out_last, busy, err}, 0);
      chk({tag, "_as"}, mul_as, 0);
      chk({tag, "_bs"}, mul_bs, 0);
      chk({tag, "_coef"}, 64'(out_coef), 0);
   endtask

   task automatic send_job(input vec_t a, input vec_t b, input bit gap,
                           input bit push, input int stray_beat);
      vec_t c;
      int guard;
      c = pmul(a, b);
      if (push) for (int i = 0; i < N; i++) exp_q.push_back(c[i]);
      for (int k = 0; k < 2 * N; k++) begin
         if (gap) begin in_valid = 1'b0; tick(); end
         in_valid = 1'b1;
         in_coef  = (k < N) ? a[k] : b[k - N];
         guard = 0;
         while (in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
         if (guard >= 50) chk("in_ready_wait", 64'(in_ready), 1);
         tick();
         if (k == stray_beat) begin
            in_valid = 1'b0;
            stray    = 1'b1;
            tick();
            stray = 1'b0;
            chk("stray_load_state", {61'd0, out_valid, in_ready, busy}, 3'b011);
         end
      end
      in_valid = 1'b0;
      chk("start_latency", 64'(mul_start), 1);
      chk("as_pack", mul_as, a);
      chk("bs_pack", mul_bs, b);
      chk("in_ready_start", 64'(in_ready), 0);
      tick();
      chk("start_one_cycle", 64'(mul_start), 0);
   endtask

   task automatic wait_done(input vec_t a, input vec_t b);
      for (int i = 0; i < 40; i++) begin
         if (mul_done === 1'b1) begin
            tick();
            chk("done_to_valid", 64'(out_valid), 1);
            return;
         end
         chk("wait_no_valid", 64'(out_valid), 0);
         chk("wait_hold_ab", {mul_as, mul_bs} == {a, b}, 1);
         tick();
      end
      chk("done_timeout", 64'(mul_done), 1);
   endtask

   task automatic drain(input int nbeats, input int stall_beat, input int stall_len,
                        input int stray_beat);
      logic [W-1:0] e;
      int guard;
      for (int j = 0; j < nbeats; j++) begin
         guard = 0;
         while (out_valid !== 1'b1 && guard < 20) begin tick(); guard++; end
         if (guard >= 20) chk("out_valid_wait", 64'(out_valid), 1);
         e = (exp_q.size() > 0) ? exp_q[0] : 'x;
         if (j == stall_beat) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               tick();
               chk("stall_valid", 64'(out_valid), 1);
               chk("stall_coef", 64'(out_coef), 64'(e));
            end
         end
         out_ready = 1'b1;
         if (j == stray_beat) stray = 1'b1;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         chk("out_coef", 64'(out_coef), 64'(e));
         chk("out_last", 64'(out_last), 64'(j == N - 1));
         tick();
         stray = 1'b0;
      end
      out_ready = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_in_ready"}, 64'(in_ready), 1);
   endtask

   initial begin
      vec_t a, b;

      // Reset state and the cycle after reset release
      tick(); tick();
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();
      chk("start_after_reset", 64'(mul_start), 0);
      check_reset_outputs("post_reset");

      // 1: a = 1..N, b = all ones
      for (int i = 0; i < N; i++) begin a[i] = W'(i + 1); b[i] = W'(1); end
      send_job(a, b, 1'b0, 1'b1, -1);
      wait_done(a, b);
      drain(N, -1, 0, -1);
      check_idle("t1_idle");

      // 2: in_valid toggled every other cycle
      send_job(a, b, 1'b1, 1'b1, -1);
      wait_done(a, b);
      drain(N, -1, 0, -1);
      check_idle("t2_idle");

      // 3: stall three cycles on beat 4
      a = rand_vec(); b = rand_vec();
      send_job(a, b, 1'b0, 1'b1, -1);
      wait_done(a, b);
      drain(N, 3, 3, -1);
      check_idle("t3_idle");

      // 4: no done -> timeout error
      model_en = 1'b0;
      a = rand_vec(); b = rand_vec();
      send_job(a, b, 1'b0, 1'b0, -1);
      for (int i = 2; i < TO; i++) begin
         tick();
         chk("to_no_err", {62'd0, err, out_valid}, 0);
      end
      tick();
      chk("to_err", 64'(err), 1);
      chk("to_in_ready", 64'(in_ready), 1);
      chk("to_no_valid", 64'(out_valid), 0);
      tick();
      chk("to_err_pulse", 64'(err), 0);
      chk("to_in_ready_next", 64'(in_ready), 1);
      model_en = 1'b1;
      a = rand_vec(); b = rand_vec();
      send_job(a, b, 1'b0, 1'b1, -1);
      wait_done(a, b);
      drain(N, -1, 0, -1);
      check_idle("t4_idle");

      // 5a: reset in WAIT, late done must be ignored
      done_delay = 6;
      a = rand_vec(); b = rand_vec();
      send_job(a, b, 1'b0, 1'b0, -1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("rst_wait");
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("late_done_ignored", {62'd0, out_valid, in_ready}, 2'b01);
      end
      check_idle("t5a_idle");

      // 5b: reset after two drain beats
      done_delay = 5;
      a = rand_vec(); b = rand_vec();
      send_job(a, b, 1'b0, 1'b1, -1);
      wait_done(a, b);
      drain(2, -1, 0, -1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("rst_drain");
      exp_q.delete();
      a = rand_vec(); b = rand_vec();
      send_job(a, b, 1'b0, 1'b1, -1);
      wait_done(a, b);
      drain(N, -1, 0, -1);
      check_idle("t5b_idle");

      // 6: stray done during LOAD and DRAIN
      a = rand_vec(); b = rand_vec();
      send_job(a, b, 1'b0, 1'b1, 4);
      wait_done(a, b);
      drain(N, -1, 0, 2);
      check_idle("t6_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
